// File: rtl/nps_outmem.sv
// nps_outmem: captures one frame of DATA_NUM stream words into a local RAM.
// It sits after nps_inmem and reads that block's vo/fo/datao stream.
//
// Ports:
//   clk, reset_x       clock and asynchronous active-low reset
//   clr                one-cycle pulse that clears status and arms capture
//   vi, fi, datai      input stream: word valid, last word, data
//   done, err          frame captured (held) and sticky frame-length error
//   wcnt               number of words stored in the current frame
//   cpu_adr, cpu_rd    CPU read address and strobe
//   cpu_datao          registered CPU read data (1-cycle latency)
module nps_outmem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DATA_NUM   = 30,
    parameter int unsigned ADR_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset_x,
    input  logic                  clr,
    input  logic                  vi,
    input  logic                  fi,
    input  logic [DATA_WIDTH-1:0] datai,
    output logic                  done,
    output logic                  err,
    output logic [ADR_WIDTH:0]    wcnt,
    input  logic [ADR_WIDTH-1:0]  cpu_adr,
    input  logic                  cpu_rd,
    output logic [DATA_WIDTH-1:0] cpu_datao
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCapture = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    localparam logic [ADR_WIDTH:0] NumW = (ADR_WIDTH + 1)'(DATA_NUM);

    logic [1:0]            state_q, state_d;
    logic [ADR_WIDTH:0]    wcnt_q, wcnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we;

    // Not reset: contents are only meaningful after a capture.
    logic [DATA_WIDTH-1:0] mem [DATA_NUM];

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        done_d  = done_q;
        err_d   = err_q;
        we      = 1'b0;
        if (clr) begin
            // A vi arriving together with clr is deliberately dropped.
            state_d = StCapture;
            wcnt_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                StCapture: begin
                    if (vi) begin
                        if (wcnt_q < NumW) begin
                            we     = 1'b1;
                            wcnt_d = wcnt_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (fi) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                            if (wcnt_d != NumW) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    if (vi) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Out-of-range addresses read as zero; registered value holds without cpu_rd.
    always_comb begin
        rdata_d = rdata_q;
        if (cpu_rd) begin
            if ({1'b0, cpu_adr} < NumW) begin
                rdata_d = mem[cpu_adr];
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Read above samples the old word when the write hits the same address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wcnt_q[ADR_WIDTH-1:0]] <= datai;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign wcnt      = wcnt_q;
    assign cpu_datao = rdata_q;

endmodule
